// File: rtl/r2sdf_stage_pkg.sv
// Shared FFT helpers: clog2 and the per-stage word-growth convention.
// A stage takes BW-bit signed samples and produces BW+GROWTH-bit signed results.
package r2sdf_stage_pkg;

  localparam int GROWTH = 1;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_BFLY = 1'b1
  } phase_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated shift chain used as the SDF feedback memory; head_o is the oldest entry.
module sdf_delay_line #(
  parameter int W     = 34,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= din_i;
    end
  end

  assign head_o = mem_q[0];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage.
// Two register stages: input capture, then butterfly result into the output register.
module r2sdf_stage
  import r2sdf_stage_pkg::*;
#(
  parameter int BW    = 16,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [BW-1:0] in_real,
  input  logic [BW-1:0] in_imag,
  output logic          out_valid,
  output logic          out_sof,
  output logic [BW:0]   out_real,
  output logic [BW:0]   out_imag
);

  localparam int OW = BW + GROWTH;
  localparam int CW = clog2(2 * DEPTH);
  localparam logic [CW-1:0] IDX_SOF = CW'(DEPTH);

  logic [BW-1:0]   xr_q, xi_q;
  logic            sof_q, rvld_q;
  logic [CW-1:0]   cnt_q, cnt_d, idx;
  logic            primed_q, primed_d;
  phase_e          ph;
  logic [OW-1:0]   xr, xi, hr, hi, res_r, res_i, push_r, push_i;
  logic [2*OW-1:0] head;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_q <= 1'b0;
      sof_q  <= 1'b0;
      xr_q   <= '0;
      xi_q   <= '0;
    end else begin
      rvld_q <= in_valid;
      if (in_valid) begin
        sof_q <= in_sof;
        xr_q  <= in_real;
        xi_q  <= in_imag;
      end
    end
  end

  always_comb begin
    idx      = sof_q ? '0 : cnt_q;
    ph       = phase_e'(idx[CW-1]);
    cnt_d    = rvld_q ? idx + CW'(1) : cnt_q;
    primed_d = primed_q | (rvld_q & (ph == PH_BFLY));
    xr       = {xr_q[BW-1], xr_q};
    xi       = {xi_q[BW-1], xi_q};
    hr       = head[2*OW-1:OW];
    hi       = head[OW-1:0];
    // Butterfly phase: emit the sum now, park the difference for the next frame.
    if (ph == PH_BFLY) begin
      res_r  = hr + xr;
      res_i  = hi + xi;
      push_r = hr - xr;
      push_i = hi - xi;
    end else begin
      res_r  = hr;
      res_i  = hi;
      push_r = xr;
      push_i = xi;
    end
  end

  sdf_delay_line #(.W(2 * OW), .DEPTH(DEPTH)) u_dly (
    .clk    (clk),
    .reset  (reset),
    .en_i   (rvld_q),
    .din_i  ({push_r, push_i}),
    .head_o (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      primed_q  <= primed_d;
      out_valid <= rvld_q & ((ph == PH_BFLY) | primed_q);
      out_sof   <= rvld_q & (idx == IDX_SOF);
      if (rvld_q) begin
        out_real <= res_r;
        out_imag <= res_i;
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench: DEPTH=2, DEPTH=1 and DEPTH=4 stages share one stimulus stream.
module tb_r2sdf_stage;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;

  logic               v1, v2, v4, s1, s2, s4;
  logic signed [16:0] r1, r2, r4, i1, i2, i4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  r2sdf_stage #(.BW(16), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(v2), .out_sof(s2), .out_real(r2), .out_imag(i2));

  r2sdf_stage #(.BW(16), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(v1), .out_sof(s1), .out_real(r1), .out_imag(i1));

  r2sdf_stage #(.BW(16), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(v4), .out_sof(s4), .out_real(r4), .out_imag(i4));

  int e2_re[8]  = '{0, 0, 4, 6, -2, -2, 0, 0};
  int e2_v[8]   = '{0, 0, 1, 1, 1, 1, 1, 1};
  int e2_sof[8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  int x1_re[5]  = '{32767, 32767, -32768, 32767, 0};
  int x1_im[5]  = '{-32768, -32768, 32767, -32768, 0};
  int e1_re[5]  = '{0, 65534, 0, -1, -65535};
  int e1_im[5]  = '{0, -65536, 0, -1, 65535};
  int e1_v[5]   = '{0, 1, 1, 1, 1};
  int e1_sof[5] = '{0, 1, 0, 1, 0};

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input int re, input int im);
    in_valid = v;
    in_sof   = s;
    in_real  = 16'(re);
    in_imag  = 16'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int v, input int re, input int im, input int sof);
    chk({tag, "_v"}, 32'(v4), v);
    chk({tag, "_re"}, 32'(r4), re);
    chk({tag, "_im"}, 32'(i4), im);
    chk({tag, "_sof"}, 32'(s4), sof);
  endtask

  // Reset with a simultaneous valid sample: reset must win and the sample vanish.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_real  = 16'sd77;
    in_imag  = 16'sd77;
    @(posedge clk);
    #1;
    chk("rst_u1_v", 32'(v1), 0);
    chk("rst_u1_re", 32'(r1), 0);
    chk("rst_u1_im", 32'(i1), 0);
    chk("rst_u2_re", 32'(r2), 0);
    chk4("rst_u4", 0, 0, 0, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 0, 0);
    chk4("rst_drop_u4", 0, 0, 0, 0);
    chk("rst_drop_u1_v", 32'(v1), 0);
  endtask

  // DEPTH=4 frame 1..8 then four zeros; optional bubbles and optional leading sof.
  task automatic run4(input bit gaps, input bit with_sof);
    int pv, pre, pim, psof, x, ere;
    pv = 0; pre = 0; pim = 0; psof = 0;
    for (int k = 0; k < 12; k++) begin
      if (gaps && (k % 3 == 1)) begin
        step(1'b0, 1'b0, 0, 0);
        chk4("d4_gap", pv, pre, pim, psof);
        pv = 0;
        psof = 0;
      end
      x = (k < 8) ? k + 1 : 0;
      step(1'b1, with_sof && (k == 0), x, -x);
      chk4("d4", pv, pre, pim, psof);
      ere  = (k < 4) ? 0 : (k < 8) ? 2 * k - 2 : -4;
      pv   = (k >= 4) ? 1 : 0;
      pre  = ere;
      pim  = -ere;
      psof = (k == 4) ? 1 : 0;
    end
    step(1'b0, 1'b0, 0, 0);
    chk4("d4_tail", pv, pre, pim, psof);
    step(1'b0, 1'b0, 0, 0);
    chk4("d4_hold", 0, pre, pim, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_u2_v", 32'(v2), 0);
    chk("init_u2_sof", 32'(s2), 0);
    chk("init_u2_re", 32'(r2), 0);
    chk("init_u2_im", 32'(i2), 0);
    reset = 1'b0;

    // DEPTH=2: 1,2,3,4 then zeros -> 4,6,-2,-2
    for (int k = 0; k < 9; k++) begin
      step(k < 8, k == 0, (k < 4) ? k + 1 : 0, 0);
      if (k >= 1) begin
        chk("d2_v", 32'(v2), e2_v[k-1]);
        chk("d2_sof", 32'(s2), e2_sof[k-1]);
        chk("d2_re", 32'(r2), e2_re[k-1]);
        chk("d2_im", 32'(i2), 0);
      end
    end
    step(1'b0, 1'b0, 0, 0);
    chk("d2_bubble_v", 32'(v2), 0);
    chk("d2_bubble_re", 32'(r2), 0);

    // DEPTH=1 full-scale extremes
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 5) step(1'b1, k == 0, x1_re[k], x1_im[k]);
      else       step(1'b0, 1'b0, 0, 0);
      if (k >= 1) begin
        chk("d1_v", 32'(v1), e1_v[k-1]);
        chk("d1_sof", 32'(s1), e1_sof[k-1]);
        chk("d1_re", 32'(r1), e1_re[k-1]);
        chk("d1_im", 32'(i1), e1_im[k-1]);
      end
    end

    // DEPTH=4 with bubbles
    do_reset();
    run4(1'b1, 1'b1);

    // Partial frame, reset, then a fresh frame without sof
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, k == 0, 9, 9);
    do_reset();
    run4(1'b0, 1'b0);

    // Mid-frame sof on the third sample restarts the index
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(k < 9, (k == 0) || (k == 2), 0, 0);
      if (k >= 1) begin
        chk("msof_sof", 32'(s4), (k - 1 == 6) ? 1 : 0);
        chk("msof_v", 32'(v4), (k - 1 >= 6) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
